// File: rtl/cond_branch_control.sv
// Conditional-branch resolve: funct3 picks one comparator flag (zero latency), plus a registered
// copy of the decision and a wrapping taken-branch counter. No backpressure; all inputs are consumed every cycle.
module cond_branch_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_w_i,
    input  logic             rst_w_i_h,
    input  logic [2:0]       funct_3_w_i,
    input  logic             eq_w_i_h,
    input  logic             gteu_w_i_h,
    input  logic             gtes_w_i_h,
    input  logic             ltu_w_i_h,
    input  logic             lts_w_i_h,
    input  logic             cmp_branch_w_i_h,
    output logic             cond_branch_w_o_h,
    output logic             illegal_w_o_h,
    output logic             cond_branch_r_o_h,
    output logic [CNT_W-1:0] taken_cnt_r_o
);

    logic             sel_flag;
    logic             reserved;
    logic             cond_branch_r_d;
    logic             cond_branch_r_q;
    logic [CNT_W-1:0] taken_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;

    // Only the selected flag reaches the result, so inconsistent flag sets cannot leak through.
    always_comb begin
        sel_flag = 1'b0;
        reserved = 1'b0;
        case (funct_3_w_i)
            3'b000:         sel_flag = eq_w_i_h;
            3'b001:         sel_flag = ~eq_w_i_h;
            3'b010, 3'b011: reserved = 1'b1;
            3'b100:         sel_flag = lts_w_i_h;
            3'b101:         sel_flag = gtes_w_i_h;
            3'b110:         sel_flag = ltu_w_i_h;
            3'b111:         sel_flag = gteu_w_i_h;
        endcase
    end

    assign cond_branch_w_o_h = cmp_branch_w_i_h & sel_flag;
    assign illegal_w_o_h     = cmp_branch_w_i_h & reserved;

    always_comb begin
        cond_branch_r_d = cond_branch_w_o_h;
        taken_cnt_d     = taken_cnt_q;
        if (cond_branch_w_o_h) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h) begin
            cond_branch_r_q <= 1'b0;
            taken_cnt_q     <= '0;
        end else begin
            cond_branch_r_q <= cond_branch_r_d;
            taken_cnt_q     <= taken_cnt_d;
        end
    end

    assign cond_branch_r_o_h = cond_branch_r_q;
    assign taken_cnt_r_o     = taken_cnt_q;

endmodule

// File: tb/tb_cond_branch_control.sv
// Directed bench for cond_branch_control: expected values queued at drive time, popped at check time.
module tb_cond_branch_control;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       f3  = 3'b000;
    logic             eq = 1'b0, gteu = 1'b0, gtes = 1'b0, ltu = 1'b0, lts = 1'b0, cmp = 1'b0;
    logic             cb_w;
    logic             ill_w;
    logic             cb_r;
    logic [CNT_W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  cb;
        logic  ill;
        string tag;
    } comb_exp_t;

    typedef struct {
        logic             r;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } seq_exp_t;

    comb_exp_t        comb_q[$];
    seq_exp_t         seq_q[$];
    logic [CNT_W-1:0] mdl_cnt;

    cond_branch_control #(.CNT_W(CNT_W)) dut (
        .clk_w_i          (clk),
        .rst_w_i_h        (rst),
        .funct_3_w_i      (f3),
        .eq_w_i_h         (eq),
        .gteu_w_i_h       (gteu),
        .gtes_w_i_h       (gtes),
        .ltu_w_i_h        (ltu),
        .lts_w_i_h        (lts),
        .cmp_branch_w_i_h (cmp),
        .cond_branch_w_o_h(cb_w),
        .illegal_w_o_h    (ill_w),
        .cond_branch_r_o_h(cb_r),
        .taken_cnt_r_o    (cnt)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [2:0] f, input logic e, input logic gu, input logic gs,
                          input logic lu, input logic ls, input logic c);
        f3 = f; eq = e; gteu = gu; gtes = gs; ltu = lu; lts = ls; cmp = c;
    endtask

    // Drive one combinational vector, queue its expectation, compare 1 ns later.
    task automatic comb_step(input logic [2:0] f, input logic e, input logic gu, input logic gs,
                             input logic lu, input logic ls, input logic c,
                             input logic exp_cb, input logic exp_ill, input string tag);
        comb_exp_t x;
        comb_exp_t got;
        x.cb = exp_cb; x.ill = exp_ill; x.tag = tag;
        set_in(f, e, gu, gs, lu, ls, c);
        comb_q.push_back(x);
        #1;
        got = comb_q.pop_front();
        checks++;
        assert (cb_w === got.cb) else begin
            errors++;
            $error("FAIL %s: cond_branch_w_o_h=%b expected %b", got.tag, cb_w, got.cb);
        end
        checks++;
        assert (ill_w === got.ill) else begin
            errors++;
            $error("FAIL %s: illegal_w_o_h=%b expected %b", got.tag, ill_w, got.ill);
        end
    endtask

    task automatic check_regs(input logic exp_r, input logic [CNT_W-1:0] exp_cnt, input string tag);
        seq_exp_t x;
        seq_exp_t got;
        x.r = exp_r; x.cnt = exp_cnt; x.tag = tag;
        seq_q.push_back(x);
        got = seq_q.pop_front();
        checks++;
        assert (cb_r === got.r) else begin
            errors++;
            $error("FAIL %s: cond_branch_r_o_h=%b expected %b", got.tag, cb_r, got.r);
        end
        checks++;
        assert (cnt === got.cnt) else begin
            errors++;
            $error("FAIL %s: taken_cnt_r_o=%0d expected %0d", got.tag, cnt, got.cnt);
        end
    endtask

    // Inputs are already applied; the expected decision is given explicitly by the caller.
    task automatic seq_edge(input logic dec, input string tag);
        seq_exp_t x;
        seq_exp_t got;
        if (dec) mdl_cnt = mdl_cnt + 1'b1;
        x.r = dec; x.cnt = mdl_cnt; x.tag = tag;
        seq_q.push_back(x);
        @(posedge clk);
        #1;
        got = seq_q.pop_front();
        checks++;
        assert (cb_r === got.r) else begin
            errors++;
            $error("FAIL %s: cond_branch_r_o_h=%b expected %b", got.tag, cb_r, got.r);
        end
        checks++;
        assert (cnt === got.cnt) else begin
            errors++;
            $error("FAIL %s: taken_cnt_r_o=%0d expected %0d", got.tag, cnt, got.cnt);
        end
    endtask

    initial begin
        logic [2:0] fl [5];
        logic       fv;
        logic [1:0] pat;
        logic       pc;
        logic       pf;
        mdl_cnt = '0;
        fl[0] = 3'b000; fl[1] = 3'b100; fl[2] = 3'b101; fl[3] = 3'b110; fl[4] = 3'b111;

        // Reset state, and combinational behaviour while reset is held.
        #2;
        check_regs(1'b0, '0, "reset_state");

        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 4; p++) begin
                pat = 2'(p);
                pf  = pat[1];
                pc  = pat[0];
                fv  = ~pf;
                case (fl[k])
                    3'b000:  comb_step(fl[k], pf, fv, fv, fv, fv, pc, pf & pc, 1'b0, $sformatf("f3_000_%0d", p));
                    3'b100:  comb_step(fl[k], fv, fv, fv, fv, pf, pc, pf & pc, 1'b0, $sformatf("f3_100_%0d", p));
                    3'b101:  comb_step(fl[k], fv, fv, pf, fv, fv, pc, pf & pc, 1'b0, $sformatf("f3_101_%0d", p));
                    3'b110:  comb_step(fl[k], fv, fv, fv, pf, fv, pc, pf & pc, 1'b0, $sformatf("f3_110_%0d", p));
                    default: comb_step(fl[k], fv, pf, fv, fv, fv, pc, pf & pc, 1'b0, $sformatf("f3_111_%0d", p));
                endcase
            end
        end

        comb_step(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bne_eq1_cmp0");
        comb_step(3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "bne_eq0_cmp0");
        comb_step(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bne_eq1_cmp1");
        comb_step(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "bne_eq0_cmp1");

        comb_step(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "rsv010_cmp1");
        comb_step(3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "rsv011_cmp1");
        comb_step(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rsv010_cmp0");
        comb_step(3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rsv011_cmp0");
        comb_step(3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "beq_unselected_ignored");

        check_regs(1'b0, '0, "reset_held_no_clock_effect");

        // Release reset away from a clock edge, then 5 taken / 2 not-taken BEQ edges.
        @(posedge clk);
        #2;
        rst = 1'b0;
        set_in(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) seq_edge(1'b1, $sformatf("beq_taken_%0d", i));
        set_in(3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        seq_edge(1'b0, "beq_not_taken_0");
        set_in(3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        seq_edge(1'b0, "beq_not_taken_cmp0");
        check_regs(1'b0, CNT_W'(5), "count_after_5_taken");
        set_in(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        seq_edge(1'b0, "reserved_no_incr_0");
        set_in(3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        seq_edge(1'b0, "reserved_no_incr_1");

        // Clear, then preset the counter to all-ones and wrap it.
        rst = 1'b1;
        #1;
        check_regs(1'b0, '0, "async_clear_before_preset");
        rst = 1'b0;
        mdl_cnt = '0;
        set_in(3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < (2 ** CNT_W) - 1; i++) begin
            @(posedge clk);
            mdl_cnt = mdl_cnt + 1'b1;
        end
        #1;
        check_regs(1'b1, {CNT_W{1'b1}}, "preset_all_ones");
        seq_edge(1'b1, "wrap_to_zero");
        check_regs(1'b1, '0, "wrap_value_zero");

        for (int i = 0; i < 3; i++) seq_edge(1'b1, $sformatf("post_wrap_%0d", i));

        // Mid-cycle reset clears at once and holds across an edge with a taken branch present.
        #2;
        rst = 1'b1;
        #1;
        check_regs(1'b0, '0, "async_reset_immediate");
        @(posedge clk);
        #1;
        check_regs(1'b0, '0, "reset_held_across_edge");
        comb_step(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "comb_during_reset");
        rst = 1'b0;
        mdl_cnt = '0;
        seq_edge(1'b1, "resume_first_edge");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
